reg_file_d: RTL and testbench
=============================

// Module: reg_file_d
// PURPOSE
//  Architectural integer register file for the pipelined RV32I core.
//  Consumer of the writeback result: W stage writes ResultW/RdW/RegWriteW on the
//  write port, D stage reads rs1/rs2 combinationally on two read ports.
//  Provides write-to-read bypass, so a D-stage read in the same cycle as a
//  W-stage write to that register sees the new value. Replaces negedge writes.
// PARAMETERS
//  DATA_WIDTH  32  register width in bits
//  ADDR_WIDTH  5   register index width; depth = 2**ADDR_WIDTH (32 regs)
//  BYPASS_EN   1   1 = same-cycle W->D bypass enabled; 0 = stored value only
// PORTS
//  clk_i        in   1           core clock, all writes on rising edge
//  rst_n_i      in   1           asynchronous reset, active low
//  RegWriteW_i  in   1           write enable from W stage
//  RdW_i        in   ADDR_WIDTH  destination register index from W stage
//  ResultW_i    in   DATA_WIDTH  writeback data (ALU / load / PC+4 result)
//  A1D_i        in   ADDR_WIDTH  rs1 index from D stage
//  A2D_i        in   ADDR_WIDTH  rs2 index from D stage
//  RD1D_o       out  DATA_WIDTH  rs1 read data to D stage
//  RD2D_o       out  DATA_WIDTH  rs2 read data to D stage
//  a0_o         out  DATA_WIDTH  live copy of x10 (a0) for testbench/display
// BEHAVIOUR
//  - Reset: rst_n_i low asynchronously clears x1..x31 to 0. While low, RD1D_o,
//    RD2D_o and a0_o read 0, and the write port is ignored.
//    A write in flight at reset assertion is lost. No partial updates.
//  - Storage: 31 flops of DATA_WIDTH. x0 is not stored; reads of index 0
//    always return 0.
//  - Write: on rising clk_i with rst_n_i high, RegWriteW_i=1 and RdW_i!=0
//    -> reg[RdW_i] <= ResultW_i. Writes to x0 are silently dropped.
//  - Read: purely combinational, zero cycles latency. RDnD_o = (AnD_i==0) ? 0 :
//    bypass_hit ? ResultW_i : reg[AnD_i].
//  - Bypass_hit (per port): BYPASS_EN && RegWriteW_i && RdW_i==AnD_i && RdW_i!=0.
//    Both ports may hit the same write simultaneously; each resolves
//    independently.
//  - With BYPASS_EN=0, a write becomes visible on read ports the cycle after
//    the edge. The hazard unit must then stall one extra cycle.
//  - a0_o reflects stored x10 only, without bypass: updates the cycle after
//    the write edge.
//  - No X-propagation from unused indices: every index 1..31 is backed by
//    reset flops.
//  - Width: no arithmetic. Indices are compared at full ADDR_WIDTH; data passes
//    unmodified.
// TESTING
//  1 Reset: pulse rst_n_i low mid-cycle after writing x5=0xDEADBEEF
//    -> all RD outputs and a0_o read 0 immediately, not waiting for clk.
//  2 Basic write/read: write x7=0x12345678, next cycle A1D=7
//    -> RD1D_o=0x12345678; A2D=8 -> RD2D_o=0.
//  3 x0 protection: RegWriteW=1, RdW=0, ResultW=0xFFFFFFFF, then A1D=A2D=0
//    -> both outputs 0 in the write cycle and every later cycle.
//  4 Bypass: same cycle RegWriteW=1, RdW=3, ResultW=0xA5A5A5A5, A1D=A2D=3,
//    x3 previously 0x1 -> RD1D=RD2D=0xA5A5A5A5 before the edge. With
//    BYPASS_EN=0 -> 0x1 before the edge, 0xA5A5A5A5 after it.
//  5 Write disabled: RegWriteW=0, RdW=4, ResultW=0x55 -> x4 is unchanged and
//    no bypass occurs.
//  6 a0 tracking: write x10=0x2A -> a0_o=0x2A from the cycle after the edge;
//    random 1000-cycle write/read sequence matches a reference model.

Source files
------------

// File: rtl/reg_file_d.sv
// rtl/reg_file_d.sv - RV32I integer register file, one write port, two read ports, W->D bypass
module reg_file_d #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS_EN  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  RegWriteW_i,
    input  logic [ADDR_WIDTH-1:0] RdW_i,
    input  logic [DATA_WIDTH-1:0] ResultW_i,
    input  logic [ADDR_WIDTH-1:0] A1D_i,
    input  logic [ADDR_WIDTH-1:0] A2D_i,
    output logic [DATA_WIDTH-1:0] RD1D_o,
    output logic [DATA_WIDTH-1:0] RD2D_o,
    output logic [DATA_WIDTH-1:0] a0_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // x0 is hardwired to zero, so storage starts at index 1
    logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];
    logic                  wr_en;

    assign wr_en = RegWriteW_i && (RdW_i != '0);

    // Write port: every stored register is cleared by reset, written on its index match
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_en && (RdW_i == ADDR_WIDTH'(i))) begin
                    regs[i] <= ResultW_i;
                end
            end
        end
    end

    // Read port 1: x0 reads zero, a same-cycle write to the index wins over storage
    always_comb begin
        RD1D_o = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (A1D_i == ADDR_WIDTH'(i)) begin
                RD1D_o = regs[i];
            end
        end
        if (BYPASS_EN && wr_en && (RdW_i == A1D_i)) begin
            RD1D_o = ResultW_i;
        end
        // The write port is ignored while in reset, so a bypass must not leak out either
        if (!rst_n_i) begin
            RD1D_o = '0;
        end
    end

    // Read port 2: same resolution as port 1, independently of it
    always_comb begin
        RD2D_o = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (A2D_i == ADDR_WIDTH'(i)) begin
                RD2D_o = regs[i];
            end
        end
        if (BYPASS_EN && wr_en && (RdW_i == A2D_i)) begin
            RD2D_o = ResultW_i;
        end
        if (!rst_n_i) begin
            RD2D_o = '0;
        end
    end

    // a0 mirror shows the stored x10 only; it never sees the bypass path
    assign a0_o = regs[10];

endmodule

// File: tb/tb_reg_file_d.sv
// tb/tb_reg_file_d.sv - scoreboard bench for reg_file_d with and without bypass
module tb_reg_file_d;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] rd1_b, rd2_b, a0_b;
    logic [31:0] rd1_n, rd2_n, a0_n;

    logic [31:0] mdl [0:31];
    logic [31:0] exp_q [$];
    int          n_cmp;
    int          n_mis;

    reg_file_d #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b1)) u_byp (
        .clk_i(clk), .rst_n_i(rst_n), .RegWriteW_i(we), .RdW_i(rd), .ResultW_i(res),
        .A1D_i(a1), .A2D_i(a2), .RD1D_o(rd1_b), .RD2D_o(rd2_b), .a0_o(a0_b)
    );

    reg_file_d #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b0)) u_nobyp (
        .clk_i(clk), .rst_n_i(rst_n), .RegWriteW_i(we), .RdW_i(rd), .ResultW_i(res),
        .A1D_i(a1), .A2D_i(a2), .RD1D_o(rd1_n), .RD2D_o(rd2_n), .a0_o(a0_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_rd(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 5'd0) return 32'h0;
        if (byp && we && rd == a && rd != 5'd0) return res;
        return mdl[a];
    endfunction

    // Update the model for the pending write, then advance to 1 time unit after the edge
    task automatic step();
        if (rst_n && we && rd != 5'd0) mdl[rd] = res;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] d, input logic [31:0] v,
                         input logic [4:0] x, input logic [4:0] y);
        we = w; rd = d; res = v; a1 = x; a2 = y;
        #2;
    endtask

    task automatic push_model();
        exp_q.push_back(model_rd(a1, 1'b1));
        exp_q.push_back(model_rd(a2, 1'b1));
        exp_q.push_back(rst_n ? mdl[10] : 32'h0);
        exp_q.push_back(model_rd(a1, 1'b0));
        exp_q.push_back(model_rd(a2, 1'b0));
        exp_q.push_back(rst_n ? mdl[10] : 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] obs [6];
        logic [31:0] e;
        drive(1'b1, 5'd3, 32'hCAFE_F00D, 5'd3, 5'd3);
        for (int k = 0; k < 6; k++) exp_q.push_back(32'h0);
        obs = '{rd1_b, rd2_b, a0_b, rd1_n, rd2_n, a0_n};
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs[k] !== e) begin
                n_mis++;
                $display("FAIL reset_initial[%0d] got=%h exp=%h", k, obs[k], e);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] obs [6];
        logic [31:0] e;
        drive(1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd8);
        exp_q.push_back(32'h1234_5678); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h1234_5678); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        obs = '{rd1_b, rd2_b, a0_b, rd1_n, rd2_n, a0_n};
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs[k] !== e) begin
                n_mis++;
                $display("FAIL basic_rw[%0d] got=%h exp=%h", k, obs[k], e);
            end
        end
        step();
    endtask

    task automatic test_x0();
        logic [31:0] obs [4];
        logic [31:0] e;
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(32'h0);
            obs = '{rd1_b, rd2_b, rd1_n, rd2_n};
            for (int k = 0; k < 4; k++) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs[k] !== e) begin
                    n_mis++;
                    $display("FAIL x0_protect[c%0d,%0d] got=%h exp=%h", c, k, obs[k], e);
                end
            end
            step();
            drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] obs [4];
        logic [31:0] e;
        drive(1'b1, 5'd3, 32'h1, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd3);
        exp_q.push_back(32'hA5A5_A5A5); exp_q.push_back(32'hA5A5_A5A5);
        exp_q.push_back(32'h1);         exp_q.push_back(32'h1);
        obs = '{rd1_b, rd2_b, rd1_n, rd2_n};
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs[k] !== e) begin
                n_mis++;
                $display("FAIL bypass_pre[%0d] got=%h exp=%h", k, obs[k], e);
            end
        end
        step();
        drive(1'b0, 5'd3, 32'h0, 5'd3, 5'd3);
        for (int k = 0; k < 4; k++) exp_q.push_back(32'hA5A5_A5A5);
        obs = '{rd1_b, rd2_b, rd1_n, rd2_n};
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs[k] !== e) begin
                n_mis++;
                $display("FAIL bypass_post[%0d] got=%h exp=%h", k, obs[k], e);
            end
        end
    endtask

    task automatic test_write_disabled();
        logic [31:0] obs [4];
        logic [31:0] e;
        drive(1'b0, 5'd4, 32'h55, 5'd4, 5'd4);
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(32'h0);
            obs = '{rd1_b, rd2_b, rd1_n, rd2_n};
            for (int k = 0; k < 4; k++) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs[k] !== e) begin
                    n_mis++;
                    $display("FAIL write_disabled[c%0d,%0d] got=%h exp=%h", c, k, obs[k], e);
                end
            end
            step();
        end
    endtask

    task automatic test_a0();
        logic [31:0] obs [6];
        logic [31:0] e;
        drive(1'b1, 5'd10, 32'h2A, 5'd10, 5'd0);
        exp_q.push_back(32'h2A); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);  exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        obs = '{rd1_b, rd2_b, a0_b, rd1_n, rd2_n, a0_n};
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs[k] !== e) begin
                n_mis++;
                $display("FAIL a0_pre[%0d] got=%h exp=%h", k, obs[k], e);
            end
        end
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd10, 5'd0);
        exp_q.push_back(32'h2A); exp_q.push_back(32'h0); exp_q.push_back(32'h2A);
        exp_q.push_back(32'h2A); exp_q.push_back(32'h0); exp_q.push_back(32'h2A);
        obs = '{rd1_b, rd2_b, a0_b, rd1_n, rd2_n, a0_n};
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs[k] !== e) begin
                n_mis++;
                $display("FAIL a0_post[%0d] got=%h exp=%h", k, obs[k], e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] obs [6];
        logic [31:0] e;
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd5, 32'h1, 5'd5, 5'd10);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) exp_q.push_back(32'h0);
        obs = '{rd1_b, rd2_b, a0_b, rd1_n, rd2_n, a0_n};
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs[k] !== e) begin
                n_mis++;
                $display("FAIL reset_mid[%0d] got=%h exp=%h", k, obs[k], e);
            end
        end
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd10);
        for (int k = 0; k < 6; k++) exp_q.push_back(32'h0);
        obs = '{rd1_b, rd2_b, a0_b, rd1_n, rd2_n, a0_n};
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs[k] !== e) begin
                n_mis++;
                $display("FAIL reset_cleared[%0d] got=%h exp=%h", k, obs[k], e);
            end
        end
        step();
    endtask

    task automatic test_random();
        logic [31:0] obs [6];
        logic [31:0] e;
        logic [4:0]  d;
        for (int c = 0; c < 1000; c++) begin
            d = 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), d, $urandom(),
                  ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31)));
            push_model();
            obs = '{rd1_b, rd2_b, a0_b, rd1_n, rd2_n, a0_n};
            for (int k = 0; k < 6; k++) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs[k] !== e) begin
                    n_mis++;
                    $display("FAIL random[c%0d,%0d] got=%h exp=%h", c, k, obs[k], e);
                end
            end
            step();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        rst_n = 1'b0;
        we = 1'b0; rd = '0; res = '0; a1 = '0; a2 = '0;
        test_reset();
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_basic();
        test_x0();
        test_bypass();
        test_write_disabled();
        test_a0();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
